// File: rtl/btn_pkg.sv
// +--------------------------------------------------------------------------+
// | btn_pkg : shared constants and per-channel status type for btn_conditioner|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package btn_pkg;

    localparam int DEF_N_CH              = 4;
    localparam int DEF_DEBOUNCE_CYCLES   = 16;
    localparam int DEF_LONG_PRESS_CYCLES = 1000;
    localparam int DEF_REPEAT_CYCLES     = 200;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic long_press;
        logic repeat_pulse;
    } btn_status_t;

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// +--------------------------------------------------------------------------+
// | btn_channel : one button channel - sync, debounce, edges, long press,    |
// |               optional auto-repeat (macro BTN_AUTOREPEAT_EN)             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        sig_in,
    output btn_status_t status
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_PRESS_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("btn_channel: cycle parameters must be >= 1");
    end

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q,  dcnt_d;
    logic [HCNT_W-1:0] hcnt_q,  hcnt_d;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;
    logic              long_q,  long_d;
    logic              rpt_q;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        state_d = state_q;
        dcnt_d  = dcnt_q;

        if (ena) begin
            if (sync2_q != state_q) begin
                if (dcnt_q == DCNT_LAST) begin
                    state_d = sync2_q;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end else begin
                dcnt_d = '0;
            end
        end

        rise_d = state_d & ~state_q;
        fall_d = ~state_d & state_q;

        // A release on the very edge the hold count would saturate must not
        // produce a long press alongside the fall pulse.
        hcnt_d = hcnt_q;
        if (!state_q || fall_d) begin
            hcnt_d = '0;
        end else if (ena && (hcnt_q < HCNT_MAX)) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end

        long_d = (hcnt_d == HCNT_MAX) && (hcnt_q != HCNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              rpt_d;

    // Repeat period runs only once the hold counter has saturated.
    always_comb begin
        rcnt_d = rcnt_q;
        rpt_d  = 1'b0;
        if (!state_q || fall_d || long_d) begin
            rcnt_d = '0;
        end else if (ena && (hcnt_q == HCNT_MAX)) begin
            if (rcnt_q == RCNT_LAST) begin
                rcnt_d = '0;
                rpt_d  = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rpt_q  <= rpt_d;
        end
    end
`else
    assign rpt_q = 1'b0;
`endif

    assign status.level        = state_q;
    assign status.rise         = rise_q;
    assign status.fall         = fall_q;
    assign status.long_press   = long_q;
    assign status.repeat_pulse = rpt_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// +--------------------------------------------------------------------------+
// | btn_conditioner : N_CH independent push-button conditioners              |
// |                   auto-repeat enabled by macro BTN_AUTOREPEAT_EN         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH              = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] sig_debounced,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    btn_status_t status [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .REPEAT_CYCLES     (REPEAT_CYCLES)
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .sig_in (sig_in[i]),
            .status (status[i])
        );

        assign sig_debounced[i] = status[i].level;
        assign rise[i]          = status[i].rise;
        assign fall[i]          = status[i].fall;
        assign long_press[i]    = status[i].long_press;
        assign repeat_pulse[i]  = status[i].repeat_pulse;
    end

endmodule

`default_nettype wire
